reg_bank_rd: RTL
================

# reg_bank_rd

Thirty-two-entry, 32-bit MIPS general-purpose register bank. It holds one write port, whose address comes from the write-register select (rt / 29 / 31 / rd), and two registered read ports that feed the A and B operand registers of the datapath. This block is the reading end of the register-write path: it stores what the write select chooses and returns rs/rt operands one cycle after a read request.

## Interface
Parameters:
- DATA_W, 32, register width
- SP_INIT, 227, reset value of register 29 ($sp)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- reg_wr  in  1  write enable
- wr_addr  in  5  write register index (output of write-register select)
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request; samples both read addresses
- rd_addr_a  in  5  rs index (instruction[25:21])
- rd_addr_b  in  5  rt index (instruction[20:16])
- rd_data_a  out  DATA_W  registered rs operand
- rd_data_b  out  DATA_W  registered rt operand
- rd_valid  out  1  high for one cycle when rd_data_a and rd_data_b are fresh

## Operation
- Storage: registers r0..r31. r0 is hardwired to 0. A write to index 0 is discarded, and a read of index 0 always returns 0.
- Reset (reset = 0, asynchronous):
  - every register clears to 0, except r29, which loads SP_INIT.
  - rd_data_a, rd_data_b and rd_valid clear to 0.
- Write: on the rising clk edge, if reg_wr = 1 and wr_addr ≠ 0, then r[wr_addr] ← wr_data.
- Read: on the rising clk edge, if rd_en = 1:
  - rd_data_a ← r[rd_addr_a] and rd_data_b ← r[rd_addr_b].
  - rd_valid ← 1.
- When rd_en = 0: rd_data_a and rd_data_b hold their previous values and rd_valid ← 0.
- Same-edge write and read to the same nonzero index: the result is governed by the Configuration section.
- Both read ports may name the same index and receive identical data.
- There is no state machine beyond the output registers. rd_valid is a one-cycle pulse per accepted read.

## Timing
- Write latency: 1 edge. The new value is visible to any read sampled on a later edge.
- Read latency: 1 edge. Addresses presented with rd_en in cycle N appear on rd_data_* and rd_valid in cycle N+1.
- Back-to-back rd_en is allowed every cycle (full throughput). rd_valid then stays high.
- Reset asserted mid-operation: all outputs go to 0 immediately, without waiting for clk. Any write in flight is lost.
- Reset deassertion: the first edge with reset = 1 may perform a write and/or a read.
- wr_addr and wr_data are don't-care while reg_wr = 0.

## Configuration
- REG_BANK_BYPASS_EN defined: on a same-edge write and read to the same nonzero index, the read port captures wr_data (write-through).
- REG_BANK_BYPASS_EN undefined: the read port captures the pre-write contents. The new value appears on the next read.
- The bypass never applies to index 0, in either build.

## Structure
- Shared package (regbank_pkg) holds:
  - REG_ZERO = 0, REG_SP = 29, REG_RA = 31
  - SP_INIT_DEFAULT = 227
  - REG_IDX_W = 5
  - these index constants are also used by the write-register select.
- One sub-module, reg_read_port, is instantiated twice. It contains the address-zero check, the optional bypass compare, and the output register.
- The storage array and the write logic live in the top module.

## Test plan
- Reset: pulse reset low between edges. Outputs go to 0 at once. After release, reading rs = 29 and rt = 0 gives rd_data_a = 227, rd_data_b = 0, rd_valid = 1 one cycle later.
- Write then read: write r8 = 0xDEADBEEF, then on the next edge read rs = 8, rt = 8. Both outputs = 0xDEADBEEF at N+1.
- Zero protection: write r0 = 0x12345678, then read rs = 0. rd_data_a = 0.
- Same-edge collision: r9 = 5; write r9 = 7 while reading rs = 9 on the same edge.
  - with REG_BANK_BYPASS_EN: rd_data_a = 7.
  - without it: rd_data_a = 5, and the next read gives 7.
- Hold and valid: read rs = 31 (value 0x40), then rd_en = 0 for 3 cycles. rd_data_a stays 0x40 and rd_valid = 0 during the idle cycles.
- Reset mid-stream: continuous reads of r8 with reset asserted asynchronously. Outputs drop to 0 before the next edge, and r8 reads 0 after release.

Source files
------------

// File: rtl/regbank_pkg.sv
// Register bank index constants and helpers.
// Shared with the write-register select logic.
package regbank_pkg;

  localparam int REG_IDX_W = 5;
  localparam int SP_INIT_DEFAULT = 227;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd31;

  function automatic logic is_zero(
    input logic [REG_IDX_W-1:0] idx
  );
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_read_port.sv
// One registered read port: r0 masking, optional write-through
// (REG_BANK_BYPASS_EN), output data and valid registers.
// Ports: clk, reset (async low), rd_en, rd_addr, mem_data in;
//        wr_en/wr_addr/wr_data in (bypass build only);
//        rd_data, rd_valid out.
module reg_read_port
  import regbank_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic [REG_IDX_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]    mem_data,
`ifdef REG_BANK_BYPASS_EN
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
`endif
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid
);

  logic [DATA_W-1:0] sel;

  always_comb begin
    sel = mem_data;
`ifdef REG_BANK_BYPASS_EN
    if (wr_en && wr_addr == rd_addr)
      sel = wr_data;
`endif
    // r0 wins over any bypass hit
    if (is_zero(rd_addr))
      sel = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= sel;
    end
  end

endmodule

// File: rtl/reg_bank_rd.sv
// 32x32 MIPS register bank, one write port, two registered read ports.
// Ports: clk, reset (async low), reg_wr, wr_addr, wr_data, rd_en,
//        rd_addr_a, rd_addr_b in; rd_data_a, rd_data_b, rd_valid out.
// Option: REG_BANK_BYPASS_EN enables same-edge write-through.
module reg_bank_rd
  import regbank_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SP_INIT = SP_INIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reg_wr,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_en,
  input  logic [REG_IDX_W-1:0] rd_addr_a,
  input  logic [REG_IDX_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_a,
  output logic [DATA_W-1:0]    rd_data_b,
  output logic                 rd_valid
);

  logic [DATA_W-1:0] regs [32];
  logic              wr_en;
  logic              va;
  logic              vb;

  assign wr_en = reg_wr && !is_zero(wr_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == int'(REG_SP)) ?
                   DATA_W'(SP_INIT) : '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  reg_read_port #(.DATA_W(DATA_W)) u_port_a (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr_a),
    .mem_data (regs[rd_addr_a]),
`ifdef REG_BANK_BYPASS_EN
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
`endif
    .rd_data  (rd_data_a),
    .rd_valid (va)
  );

  reg_read_port #(.DATA_W(DATA_W)) u_port_b (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr_b),
    .mem_data (regs[rd_addr_b]),
`ifdef REG_BANK_BYPASS_EN
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
`endif
    .rd_data  (rd_data_b),
    .rd_valid (vb)
  );

  // Both ports see the same rd_en, so the valids always agree
  assign rd_valid = va & vb;

endmodule
